// File: rtl/sdhci_cmd_arbiter.sv
// sdhci_cmd_arbiter
// Arbitrates the SD CMD line between driver-issued commands and the auto-CMD12
// (STOP_TRANSMISSION) request from the data path. Requests are latched as pending
// flags. A pending CMD12 always wins. Completion errors on one owner cancel the
// pending command of the other owner and are recorded in a W1C status register.
//
// Ports:
//   clk_i, rst_ni              clock, asynchronous active-low reset
//   drv_cmd_*_i                driver command request and payload (single-cycle valid)
//   acmd12_req_i               auto-CMD12 request pulse from the data path
//   cmd_valid_o/cmd_ready_i    command handshake toward the CMD-line sequencer
//   cmd_*_o                    command payload, forced to zero while not issuing
//   cmd_done_i, cmd_err_i      response-phase completion {index,end,crc,timeout}
//   drv_cmd_busy_o             driver command pending or in flight
//   drv_cmd_done_o/err_o       driver completion pulse, error held until next completion
//   drv_cmd_dropped_o          driver command cancelled by a failed CMD12
//   acmd12_done_o              CMD12 completion pulse
//   acmd_err_status_o          auto-CMD error status (W1C via acmd_err_clr_i)
//   acmd_err_int_o             level interrupt, |acmd_err_status_o[4:0]
module sdhci_cmd_arbiter (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        drv_cmd_valid_i,
  input  logic [5:0]  drv_cmd_index_i,
  input  logic [31:0] drv_cmd_arg_i,
  input  logic [1:0]  drv_cmd_resp_type_i,
  input  logic        drv_cmd_crc_chk_i,
  input  logic        drv_cmd_idx_chk_i,
  input  logic        acmd12_req_i,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [5:0]  cmd_index_o,
  output logic [31:0] cmd_arg_o,
  output logic [1:0]  cmd_resp_type_o,
  output logic        cmd_crc_chk_o,
  output logic        cmd_idx_chk_o,
  input  logic        cmd_done_i,
  input  logic [3:0]  cmd_err_i,
  output logic        drv_cmd_busy_o,
  output logic        drv_cmd_done_o,
  output logic [3:0]  drv_cmd_err_o,
  output logic        drv_cmd_dropped_o,
  output logic        acmd12_done_o,
  output logic [7:0]  acmd_err_status_o,
  input  logic [7:0]  acmd_err_clr_i,
  output logic        acmd_err_int_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWaitResp} state_e;
  typedef enum logic {OwnDrv, OwnAcmd} owner_e;

  state_e      state_q;
  owner_e      owner_q;
  logic        drv_pend_q;
  logic        acmd_pend_q;
  logic [5:0]  drv_index_q;
  logic [31:0] drv_arg_q;
  logic [1:0]  drv_resp_type_q;
  logic        drv_crc_chk_q;
  logic        drv_idx_chk_q;
  logic        drv_done_q;
  logic [3:0]  drv_err_q;
  logic        drv_dropped_q;
  logic        acmd_done_q;
  logic [7:0]  status_q;
  logic [7:0]  status_set;
  logic [7:0]  status_d;

  logic busy;
  logic acmd_in_flight;
  logic drv_accept;
  logic acmd_accept;
  logic done_evt;
  logic err_any;

  assign busy           = drv_pend_q | ((owner_q == OwnDrv) && (state_q != StIdle));
  assign acmd_in_flight = (owner_q == OwnAcmd) && (state_q != StIdle);
  assign drv_accept     = drv_cmd_valid_i & ~busy;
  assign acmd_accept    = acmd12_req_i & ~acmd_pend_q & ~acmd_in_flight;
  assign done_evt       = (state_q == StWaitResp) & cmd_done_i;
  assign err_any        = |cmd_err_i;

  // Status bits: [0] CMD12 not executed, [4:1] CMD12 {index,end,crc,timeout},
  // [7] driver command dropped; [6:5] reserved.
  always_comb begin
    status_set = 8'h00;
    if (done_evt && (owner_q == OwnDrv)) begin
      status_set[0] = err_any & acmd_pend_q;
    end
    if (done_evt && (owner_q == OwnAcmd)) begin
      status_set[4:1] = cmd_err_i;
      status_set[7]   = err_any & drv_pend_q;
    end
    // A set in the same cycle as its clear must survive.
    status_d = ((status_q & ~acmd_err_clr_i) | status_set) & 8'h9f;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q         <= StIdle;
      owner_q         <= OwnDrv;
      drv_pend_q      <= 1'b0;
      acmd_pend_q     <= 1'b0;
      drv_index_q     <= '0;
      drv_arg_q       <= '0;
      drv_resp_type_q <= '0;
      drv_crc_chk_q   <= 1'b0;
      drv_idx_chk_q   <= 1'b0;
      drv_done_q      <= 1'b0;
      drv_err_q       <= '0;
      drv_dropped_q   <= 1'b0;
      acmd_done_q     <= 1'b0;
      status_q        <= '0;
    end else begin
      drv_done_q    <= 1'b0;
      drv_dropped_q <= 1'b0;
      acmd_done_q   <= 1'b0;
      status_q      <= status_d;

      if (drv_accept) begin
        drv_pend_q      <= 1'b1;
        drv_index_q     <= drv_cmd_index_i;
        drv_arg_q       <= drv_cmd_arg_i;
        drv_resp_type_q <= drv_cmd_resp_type_i;
        drv_crc_chk_q   <= drv_cmd_crc_chk_i;
        drv_idx_chk_q   <= drv_cmd_idx_chk_i;
      end
      if (acmd_accept) begin
        acmd_pend_q <= 1'b1;
      end

      unique case (state_q)
        StIdle: begin
          if (acmd_pend_q) begin
            owner_q <= OwnAcmd;
            state_q <= StIssue;
          end else if (drv_pend_q) begin
            owner_q <= OwnDrv;
            state_q <= StIssue;
          end
        end
        StIssue: begin
          if (cmd_ready_i) begin
            state_q <= StWaitResp;
            if (owner_q == OwnAcmd) acmd_pend_q <= 1'b0;
            else                    drv_pend_q  <= 1'b0;
          end
        end
        StWaitResp: begin
          if (cmd_done_i) begin
            state_q <= StIdle;
            if (owner_q == OwnDrv) begin
              drv_done_q <= 1'b1;
              drv_err_q  <= cmd_err_i;
              // A failed driver command means the data transfer it closed is
              // broken; the queued CMD12 is abandoned.
              if (err_any && acmd_pend_q) acmd_pend_q <= 1'b0;
            end else begin
              acmd_done_q <= 1'b1;
              if (err_any && drv_pend_q) begin
                drv_pend_q    <= 1'b0;
                drv_dropped_q <= 1'b1;
              end
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    cmd_valid_o     = (state_q == StIssue);
    cmd_index_o     = '0;
    cmd_arg_o       = '0;
    cmd_resp_type_o = '0;
    cmd_crc_chk_o   = 1'b0;
    cmd_idx_chk_o   = 1'b0;
    if (cmd_valid_o) begin
      if (owner_q == OwnAcmd) begin
        // STOP_TRANSMISSION, R1b
        cmd_index_o     = 6'd12;
        cmd_arg_o       = 32'h0;
        cmd_resp_type_o = 2'b11;
        cmd_crc_chk_o   = 1'b1;
        cmd_idx_chk_o   = 1'b1;
      end else begin
        cmd_index_o     = drv_index_q;
        cmd_arg_o       = drv_arg_q;
        cmd_resp_type_o = drv_resp_type_q;
        cmd_crc_chk_o   = drv_crc_chk_q;
        cmd_idx_chk_o   = drv_idx_chk_q;
      end
    end
  end

  assign drv_cmd_busy_o    = busy;
  assign drv_cmd_done_o    = drv_done_q;
  assign drv_cmd_err_o     = drv_err_q;
  assign drv_cmd_dropped_o = drv_dropped_q;
  assign acmd12_done_o     = acmd_done_q;
  assign acmd_err_status_o = status_q;
  assign acmd_err_int_o    = |status_q[4:0];

endmodule
